// File: rtl/algol_bus_pkg.sv
// Shared bus definitions for the fetch/load-store memory arbiter.
// Holds the grant-state enum, the port ids and the request bundle.
package algol_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int WAIT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_I = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  wsel;
        logic              valid;
    } bus_req_t;

    function automatic arb_state_e grant_state(input port_id_t port);
        return (port == PORT_D) ? GNT_D : GNT_I;
    endfunction

    function automatic port_id_t other_port(input port_id_t port);
        return (port == PORT_D) ? PORT_I : PORT_D;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for the granted access; expired flags TIMEOUT waiting cycles.
// Saturates at the limit so a stuck enable can never wrap back to zero.
module mem_arb_timer
    import algol_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one shared memory bus.
// Registered grant, alternating priority on contention, per-access timeout.
module mem_arbiter
    import algol_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] iport_address,
    input  logic [DATA_W-1:0] iport_wdata,
    input  logic [SEL_W-1:0]  iport_wsel,
    input  logic              iport_valid,
    output logic [DATA_W-1:0] iport_rdata,
    output logic              iport_ready,
    output logic              iport_error,

    input  logic [ADDR_W-1:0] dport_address,
    input  logic [DATA_W-1:0] dport_wdata,
    input  logic [SEL_W-1:0]  dport_wsel,
    input  logic              dport_valid,
    output logic [DATA_W-1:0] dport_rdata,
    output logic              dport_ready,
    output logic              dport_error,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [SEL_W-1:0]  mem_wsel,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_error
);

    arb_state_e state_q;
    arb_state_e state_d;
    port_id_t   last_q;
    port_id_t   last_d;

    bus_req_t   ireq;
    bus_req_t   dreq;
    bus_req_t   sel_req;
    port_id_t   gnt_port;
    logic       granted;
    logic       cur_valid;
    logic       other_valid;
    logic       expired;
    logic       complete;
    logic       abort;
    logic       resp_ready;
    logic       resp_error;
    logic       timer_clear;
    logic       timer_enable;

    assign ireq = '{address: iport_address, wdata: iport_wdata, wsel: iport_wsel, valid: iport_valid};
    assign dreq = '{address: dport_address, wdata: dport_wdata, wsel: dport_wsel, valid: dport_valid};

    assign granted     = (state_q != IDLE);
    assign gnt_port    = (state_q == GNT_D) ? PORT_D : PORT_I;
    assign sel_req     = (gnt_port == PORT_D) ? dreq : ireq;
    assign other_valid = (gnt_port == PORT_D) ? iport_valid : dport_valid;

    // An access ends on a memory response or on timeout; dropping valid is an abort.
    assign cur_valid  = granted && sel_req.valid;
    assign abort      = granted && !sel_req.valid;
    assign resp_ready = cur_valid && mem_ready;
    assign resp_error = cur_valid && (mem_error || expired);
    assign complete   = cur_valid && (mem_ready || mem_error || expired);

    // Any state change is a fresh grant (or a return to IDLE), so the count restarts.
    assign timer_clear  = (state_d != state_q);
    assign timer_enable = cur_valid && !complete;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= PORT_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (iport_valid && dport_valid) begin
                    state_d = grant_state(other_port(last_q));
                end else if (iport_valid) begin
                    state_d = GNT_I;
                end else if (dport_valid) begin
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (abort) begin
                    state_d = IDLE;
                    last_d  = gnt_port;
                end else if (complete) begin
                    last_d  = gnt_port;
                    state_d = other_valid ? grant_state(other_port(gnt_port)) : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_wsel    = '0;
        mem_valid   = 1'b0;
        iport_rdata = '0;
        iport_ready = 1'b0;
        iport_error = 1'b0;
        dport_rdata = '0;
        dport_ready = 1'b0;
        dport_error = 1'b0;
        if (granted) begin
            mem_address = sel_req.address;
            mem_wdata   = sel_req.wdata;
            mem_wsel    = sel_req.wsel;
            mem_valid   = sel_req.valid && !expired;
            if (gnt_port == PORT_D) begin
                dport_rdata = mem_rdata;
                dport_ready = resp_ready;
                dport_error = resp_error;
            end else begin
                iport_rdata = mem_rdata;
                iport_ready = resp_ready;
                iport_error = resp_error;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] iport_address, iport_wdata, iport_rdata;
    logic [3:0]  iport_wsel;
    logic        iport_valid, iport_ready, iport_error;
    logic [31:0] dport_address, dport_wdata, dport_rdata;
    logic [3:0]  dport_wsel;
    logic        dport_valid, dport_ready, dport_error;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_wsel;
    logic        mem_valid, mem_ready, mem_error;
    logic        rdy_en;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iport_address (iport_address),
        .iport_wdata   (iport_wdata),
        .iport_wsel    (iport_wsel),
        .iport_valid   (iport_valid),
        .iport_rdata   (iport_rdata),
        .iport_ready   (iport_ready),
        .iport_error   (iport_error),
        .dport_address (dport_address),
        .dport_wdata   (dport_wdata),
        .dport_wsel    (dport_wsel),
        .dport_valid   (dport_valid),
        .dport_rdata   (dport_rdata),
        .dport_ready   (dport_ready),
        .dport_error   (dport_error),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_wsel      (mem_wsel),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .mem_error     (mem_error)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
    endfunction

    // Zero-wait-capable memory: answers only a valid request; bit 31 set is out of range.
    assign mem_ready = mem_valid && rdy_en && !mem_address[31];
    assign mem_error = mem_valid && rdy_en && mem_address[31];
    assign mem_rdata = mem_word(mem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        iport_address = '0; iport_wdata = '0; iport_wsel = '0; iport_valid = 1'b0;
        dport_address = '0; dport_wdata = '0; dport_wsel = '0; dport_valid = 1'b0;
        rdy_en = 1'b0;
    endtask

    // Leaves the bench at posedge+1 of the first cycle after release, DUT idle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%0b exp=0", mem_valid); end
        checks++; if (mem_wsel !== 4'h0) begin failures++; $display("FAIL reset_mem_wsel got=%h exp=0", mem_wsel); end
        checks++; if ({iport_ready, iport_error} !== 2'b00) begin failures++; $display("FAIL reset_iport_resp got=%b exp=00", {iport_ready, iport_error}); end
        checks++; if ({dport_ready, dport_error} !== 2'b00) begin failures++; $display("FAIL reset_dport_resp got=%b exp=00", {dport_ready, dport_error}); end
        do_reset();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%0b exp=0", mem_valid); end
        $display("reset: outputs idle after release");
    endtask

    task automatic test_single_read();
        logic [31:0] exp_data;
        exp_data = mem_word(32'h0000_0100);
        iport_valid = 1'b1; iport_address = 32'h0000_0100; rdy_en = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL single_cycle0_valid got=%0b exp=0", mem_valid); end
        @(posedge clk); #1;
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL single_mem_valid got=%0b exp=1", mem_valid); end
        checks++; if (mem_address !== 32'h0000_0100) begin failures++; $display("FAIL single_mem_address got=%h exp=00000100", mem_address); end
        checks++; if (iport_ready !== 1'b1) begin failures++; $display("FAIL single_iport_ready got=%0b exp=1", iport_ready); end
        checks++; if (iport_rdata !== exp_data) begin failures++; $display("FAIL single_rdata got=%h exp=%h", iport_rdata, exp_data); end
        checks++; if (dport_ready !== 1'b0) begin failures++; $display("FAIL single_dport_ready got=%0b exp=0", dport_ready); end
        $display("single_read: addr=%h rdata=%h", mem_address, iport_rdata);
        @(posedge clk); #1;
        clear_inputs();
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL single_back_idle got=%0b exp=0", mem_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        iport_valid = 1'b1; iport_address = 32'h0000_1000;
        dport_valid = 1'b1; dport_address = 32'h0000_2000; rdy_en = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_address !== 32'h0000_1000) begin failures++; $display("FAIL b2b_first_addr got=%h exp=00001000", mem_address); end
        checks++; if ({iport_ready, dport_ready} !== 2'b10) begin failures++; $display("FAIL b2b_first_ready got=%b exp=10", {iport_ready, dport_ready}); end
        @(posedge clk); #1;
        iport_valid = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%0b exp=1", mem_valid); end
        checks++; if (mem_address !== 32'h0000_2000) begin failures++; $display("FAIL b2b_second_addr got=%h exp=00002000", mem_address); end
        checks++; if ({iport_ready, dport_ready} !== 2'b01) begin failures++; $display("FAIL b2b_second_ready got=%b exp=01", {iport_ready, dport_ready}); end
        $display("back_to_back: iport then dport served without gap");
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_rd;
        do_reset();
        iport_valid = 1'b1; iport_address = 32'h0000_0300;
        dport_valid = 1'b1; dport_address = 32'h0000_0400; rdy_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_rd = (k % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if ({iport_ready, dport_ready} !== exp_rd) begin failures++; $display("FAIL alternate_k%0d got=%b exp=%b", k, {iport_ready, dport_ready}, exp_rd); end
            $display("alternate: access %0d served by %s", k, iport_ready ? "iport" : "dport");
        end
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_write_error();
        dport_valid = 1'b1; dport_address = 32'h8000_0000;
        dport_wdata = 32'hDEAD_BEEF; dport_wsel = 4'b0011; rdy_en = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_mem_wdata got=%h exp=deadbeef", mem_wdata); end
        checks++; if (mem_wsel !== 4'b0011) begin failures++; $display("FAIL wr_mem_wsel got=%b exp=0011", mem_wsel); end
        checks++; if ({dport_ready, dport_error} !== 2'b01) begin failures++; $display("FAIL wr_dport_resp got=%b exp=01", {dport_ready, dport_error}); end
        checks++; if ({iport_ready, iport_error} !== 2'b00) begin failures++; $display("FAIL wr_iport_resp got=%b exp=00", {iport_ready, iport_error}); end
        $display("write_error: addr=%h wdata=%h error=%0b", mem_address, mem_wdata, dport_error);
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        dport_valid = 1'b1; dport_address = 32'h0000_0040; rdy_en = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            checks++; if ({mem_valid, dport_error} !== 2'b10) begin failures++; $display("FAIL timeout_wait%0d got=%b exp=10", k, {mem_valid, dport_error}); end
        end
        @(posedge clk); #1;
        checks++; if ({mem_valid, dport_error, dport_ready} !== 3'b010) begin failures++; $display("FAIL timeout_pulse got=%b exp=010", {mem_valid, dport_error, dport_ready}); end
        $display("timeout: dport error after %0d waiting cycles", TMO);
        @(posedge clk); #1;
        checks++; if ({mem_valid, dport_error} !== 2'b00) begin failures++; $display("FAIL timeout_idle got=%b exp=00", {mem_valid, dport_error}); end
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        iport_valid = 1'b1; iport_address = 32'h0000_0200; iport_wsel = 4'hF; rdy_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rstmid_granted got=%0b exp=1", mem_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_valid, iport_ready, iport_error, dport_ready, dport_error} !== 5'b0) begin failures++; $display("FAIL rstmid_async got=%b exp=00000", {mem_valid, iport_ready, iport_error, dport_ready, dport_error}); end
        checks++; if (mem_wsel !== 4'h0) begin failures++; $display("FAIL rstmid_wsel got=%h exp=0", mem_wsel); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_early_grant got=%0b exp=0", mem_valid); end
        @(posedge clk); #1;
        checks++; if ({mem_valid, iport_ready, iport_error} !== 3'b100) begin failures++; $display("FAIL rstmid_regrant got=%b exp=100", {mem_valid, iport_ready, iport_error}); end
        rdy_en = 1'b1;
        #1;
        checks++; if (iport_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", iport_ready); end
        $display("reset_mid: iport regranted one edge after release");
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int          owner, nxt, waited, last, served;
        logic        done;
        logic [31:0] a [2];
        logic [31:0] w [2];
        logic [3:0]  s [2];
        logic        pend [2];
        logic        e_rdy [2];
        logic        e_err [2];
        logic        e_mv;
        do_reset();
        owner = -1; waited = 0; last = 1; served = 0;
        pend = '{1'b0, 1'b0};
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && $urandom_range(19) == 0) begin
                    pend[p] = 1'b0;
                end else if (!pend[p] && $urandom_range(1) == 1) begin
                    pend[p] = 1'b1;
                    a[p] = $urandom & 32'h0000_FFFC;
                    if ($urandom_range(7) == 0) a[p][31] = 1'b1;
                    w[p] = $urandom;
                    s[p] = 4'($urandom);
                end
            end
            iport_valid = pend[0]; iport_address = a[0]; iport_wdata = w[0]; iport_wsel = s[0];
            dport_valid = pend[1]; dport_address = a[1]; dport_wdata = w[1]; dport_wsel = s[1];
            rdy_en = ($urandom_range(9) < 6);
            #2;
            e_mv = 1'b0; e_rdy = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0}; nxt = owner; done = 1'b0;
            if (owner < 0) begin
                waited = 0;
                if (pend[0] && pend[1]) nxt = (last == 1) ? 0 : 1;
                else if (pend[0]) nxt = 0;
                else if (pend[1]) nxt = 1;
                else nxt = -1;
            end else if (!pend[owner]) begin
                last = owner; nxt = -1;
            end else begin
                if (waited == TMO) begin
                    e_err[owner] = 1'b1; done = 1'b1;
                end else begin
                    e_mv = 1'b1;
                    if (rdy_en) begin
                        done = 1'b1;
                        if (a[owner][31]) e_err[owner] = 1'b1; else e_rdy[owner] = 1'b1;
                    end else begin
                        waited++;
                    end
                end
                if (done) begin
                    last = owner; waited = 0;
                    nxt = pend[1-owner] ? 1 - owner : -1;
                end
            end
            checks++; if (mem_valid !== e_mv) begin failures++; $display("FAIL rand_c%0d_mem_valid got=%0b exp=%0b", c, mem_valid, e_mv); end
            if (e_mv) begin
                checks++; if ({mem_address, mem_wdata, mem_wsel} !== {a[owner], w[owner], s[owner]}) begin failures++; $display("FAIL rand_c%0d_mem_req got=%h/%h/%h exp=%h/%h/%h", c, mem_address, mem_wdata, mem_wsel, a[owner], w[owner], s[owner]); end
            end
            if (owner < 0) begin
                checks++; if (mem_wsel !== 4'h0) begin failures++; $display("FAIL rand_c%0d_idle_wsel got=%h exp=0", c, mem_wsel); end
            end
            checks++; if ({iport_ready, iport_error} !== {e_rdy[0], e_err[0]}) begin failures++; $display("FAIL rand_c%0d_iport_resp got=%b exp=%b", c, {iport_ready, iport_error}, {e_rdy[0], e_err[0]}); end
            checks++; if ({dport_ready, dport_error} !== {e_rdy[1], e_err[1]}) begin failures++; $display("FAIL rand_c%0d_dport_resp got=%b exp=%b", c, {dport_ready, dport_error}, {e_rdy[1], e_err[1]}); end
            if (e_rdy[0]) begin
                checks++; if (iport_rdata !== mem_word(a[0])) begin failures++; $display("FAIL rand_c%0d_iport_rdata got=%h exp=%h", c, iport_rdata, mem_word(a[0])); end
            end
            if (e_rdy[1]) begin
                checks++; if (dport_rdata !== mem_word(a[1])) begin failures++; $display("FAIL rand_c%0d_dport_rdata got=%h exp=%h", c, dport_rdata, mem_word(a[1])); end
            end
            for (int p = 0; p < 2; p++) begin
                if (e_rdy[p] || e_err[p]) begin
                    pend[p] = 1'b0;
                    served++;
                    $display("random: cycle %0d %s addr=%h %s", c, (p == 0) ? "iport" : "dport", a[p], e_err[p] ? "error" : "ready");
                end
            end
            owner = nxt;
            @(posedge clk); #1;
        end
        $display("random: %0d accesses completed", served);
        clear_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_alternate();
        test_write_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
